pic_compare_display: RTL and testbench

PIC_COMPARE_DISPLAY -- requirements
Module: pic_compare_display

---
 rtl/pic_compare_display.sv | 193 +++++++++++++++++++
 tb/tb_pic_compare_display.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pic_compare_display.sv
// Picture compare display: renders a ROM picture in a window, optionally contrast-adjusted,
// or original and adjusted side by side using a one-line buffer for the copy window.
module pic_compare_display #(
    parameter int          PIC_X_START = 10,
    parameter int          PIC_Y_START = 10,
    parameter int          PIC_WIDTH   = 200,
    parameter int          PIC_HEIGHT  = 200,
    parameter int          ADDR_W      = 16,
    parameter int          GAIN_FRAC   = 2,
    parameter logic [23:0] BACK_COLOR  = 24'hE0FFFF
) (
    input  logic              pixel_clk,
    input  logic              sys_rst_n,
    input  logic [10:0]       pixel_xpos,
    input  logic [10:0]       pixel_ypos,
    input  logic [1:0]        mode,
    input  logic [3:0]        gain,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [23:0]       rom_rd_data,
    output logic [23:0]       pixel_data,
    output logic              fifo_ovf,
    output logic              fifo_udf
);

    localparam logic [11:0] W_X0 = 12'(PIC_X_START);
    localparam logic [11:0] W_X1 = 12'(PIC_X_START + PIC_WIDTH);
    localparam logic [11:0] C_X1 = 12'(PIC_X_START + 2 * PIC_WIDTH);
    localparam logic [11:0] W_Y0 = 12'(PIC_Y_START);
    localparam logic [11:0] W_Y1 = 12'(PIC_Y_START + PIC_HEIGHT);
    localparam int          PTR_W = (PIC_WIDTH > 1) ? $clog2(PIC_WIDTH) : 1;
    localparam int          CNT_W = $clog2(PIC_WIDTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(PIC_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PIC_WIDTH);
    localparam logic [3:0]  GAIN_ONE = 4'(1 << GAIN_FRAC);

    // First adjustment stage: signed (in-128)*gain with arithmetic fractional shift.
    function automatic logic signed [12:0] adj_scale(input logic [7:0] c, input logic [3:0] g);
        logic signed [12:0] d;
        logic signed [12:0] p;
        d = $signed({5'b0_0000, c}) - 13'sd128;
        p = d * $signed({9'b0_0000_0000, g});
        return p >>> GAIN_FRAC;
    endfunction

    // Second adjustment stage: re-centre and saturate to 0..255.
    function automatic logic [7:0] adj_clamp(input logic signed [12:0] p);
        logic signed [12:0] s;
        s = p + 13'sd128;
        if (s < 13'sd0) begin
            return 8'h00;
        end else if (s > 13'sd255) begin
            return 8'hFF;
        end else begin
            return s[7:0];
        end
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    logic [1:0]              mode_q, mode_d;
    logic [3:0]              gain_q, gain_d;
    logic [ADDR_W-1:0]       rom_addr_q, rom_addr_d;
    logic [23:0]             pixel_q, pixel_d;
    logic                    ovf_q, ovf_d, udf_q, udf_d;
    logic signed [12:0]      s1_r_q, s1_r_d, s1_g_q, s1_g_d, s1_b_q, s1_b_d;
    logic                    v1_q, v1_d, v2_q, v2_d;
    logic [23:0]             s2_q, s2_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [23:0]             lb_rd_q, lb_rd_d;
    logic [23:0]             lb_mem_q [PIC_WIDTH];

    logic [11:0] x_s, y_s, x_rd_s, x_pf_s;
    logic        frame_start_s, y_in_s, in_w_s, in_c_s, pf_s;
    logic        rd_en_s, wr_en_s, rd_ok_s, wr_ok_s;

    // Window decode, widened to 12 bits so look-ahead coordinates never wrap.
    always_comb begin
        x_s           = {1'b0, pixel_xpos};
        y_s           = {1'b0, pixel_ypos};
        x_rd_s        = x_s + 12'd1;
        x_pf_s        = (mode_q == 2'd2) ? (x_s + 12'd3) : (x_s + 12'd1);
        frame_start_s = (pixel_xpos == 11'd0) && (pixel_ypos == 11'd0);
        y_in_s        = (y_s >= W_Y0) && (y_s < W_Y1);
        in_w_s        = y_in_s && (x_s >= W_X0) && (x_s < W_X1);
        in_c_s        = y_in_s && (x_s >= W_X1) && (x_s < C_X1);
        pf_s          = (mode_q != 2'd0) && y_in_s && (x_pf_s >= W_X0) && (x_pf_s < W_X1);
        rd_en_s       = (mode_q == 2'd3) && y_in_s && (x_rd_s >= W_X1) && (x_rd_s < C_X1);
        wr_en_s       = v2_q;
        wr_ok_s       = wr_en_s && (cnt_q != CNT_FULL);
        rd_ok_s       = rd_en_s && (cnt_q != '0);
    end

    // Next-state for frame settings, ROM address, adjust pipeline, line buffer and output.
    always_comb begin
        mode_d = frame_start_s ? mode : mode_q;
        gain_d = frame_start_s ? gain : gain_q;

        if (frame_start_s || (y_s >= W_Y1)) begin
            rom_addr_d = '0;
        end else if (pf_s) begin
            rom_addr_d = rom_addr_q + ADDR_W'(1);
        end else begin
            rom_addr_d = rom_addr_q;
        end

        s1_r_d = adj_scale(rom_rd_data[7:0], gain_q);
        s1_g_d = adj_scale(rom_rd_data[15:8], gain_q);
        s1_b_d = adj_scale(rom_rd_data[23:16], gain_q);
        v1_d   = (mode_q == 2'd3) && in_w_s;
        v2_d   = v1_q;
        s2_d   = {adj_clamp(s1_b_q), adj_clamp(s1_g_q), adj_clamp(s1_r_q)};

        ovf_d   = ovf_q | (wr_en_s & ~wr_ok_s);
        udf_d   = udf_q | (rd_en_s & ~rd_ok_s);
        lb_rd_d = rd_en_s ? (rd_ok_s ? lb_mem_q[rd_ptr_q] : 24'h00_0000) : lb_rd_q;

        if (pixel_xpos == 11'd0) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            wr_ptr_d = wr_ok_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
            rd_ptr_d = rd_ok_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
            case ({wr_ok_s, rd_ok_s})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end

        case (mode_q)
            2'd1:    pixel_d = in_w_s ? rom_rd_data : BACK_COLOR;
            2'd2:    pixel_d = in_w_s ? s2_q : BACK_COLOR;
            2'd3:    pixel_d = in_w_s ? rom_rd_data : (in_c_s ? lb_rd_q : BACK_COLOR);
            default: pixel_d = BACK_COLOR;
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode_q     <= 2'd0;
            gain_q     <= GAIN_ONE;
            rom_addr_q <= '0;
            pixel_q    <= BACK_COLOR;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            s1_r_q     <= 13'sd0;
            s1_g_q     <= 13'sd0;
            s1_b_q     <= 13'sd0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            s2_q       <= 24'h00_0000;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            lb_rd_q    <= 24'h00_0000;
        end else begin
            mode_q     <= mode_d;
            gain_q     <= gain_d;
            rom_addr_q <= rom_addr_d;
            pixel_q    <= pixel_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            s1_r_q     <= s1_r_d;
            s1_g_q     <= s1_g_d;
            s1_b_q     <= s1_b_d;
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            s2_q       <= s2_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            lb_rd_q    <= lb_rd_d;
        end
    end

    // Line-buffer storage; contents need no reset since pointers gate every read.
    always_ff @(posedge pixel_clk) begin
        if (wr_ok_s) begin
            lb_mem_q[wr_ptr_q] <= s2_q;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign pixel_data = pixel_q;
    assign fifo_ovf   = ovf_q;
    assign fifo_udf   = udf_q;

endmodule

// File: tb/tb_pic_compare_display.sv
// Randomized self-checking bench for pic_compare_display on a small picture geometry,
// checked against a frame-level colour model.
module tb_pic_compare_display;

    localparam int          XS    = 4;
    localparam int          YS    = 2;
    localparam int          W     = 10;
    localparam int          H     = 4;
    localparam int          AW    = 6;
    localparam int          GF    = 2;
    localparam logic [23:0] BACK  = 24'hE0FFFF;
    localparam int          H_TOT = XS + 2 * W + 3;
    localparam int          V_TOT = YS + H + 2;

    logic          pixel_clk;
    logic          sys_rst_n;
    logic [10:0]   pixel_xpos;
    logic [10:0]   pixel_ypos;
    logic [1:0]    mode;
    logic [3:0]    gain;
    logic [AW-1:0] rom_addr;
    logic [23:0]   rom_rd_data;
    logic [23:0]   pixel_data;
    logic          fifo_ovf;
    logic          fifo_udf;

    logic [23:0] rom_mem [1 << AW];
    int          n_vec;
    int          n_err;
    logic [1:0]  m_mode;
    logic [3:0]  m_gain;
    logic [1:0]  f_mode;
    logic [3:0]  f_gain;
    int          rst_x;
    int          rst_y;

    pic_compare_display #(
        .PIC_X_START(XS), .PIC_Y_START(YS), .PIC_WIDTH(W), .PIC_HEIGHT(H),
        .ADDR_W(AW), .GAIN_FRAC(GF), .BACK_COLOR(BACK)
    ) dut (
        .pixel_clk(pixel_clk), .sys_rst_n(sys_rst_n),
        .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
        .mode(mode), .gain(gain),
        .rom_addr(rom_addr), .rom_rd_data(rom_rd_data),
        .pixel_data(pixel_data), .fifo_ovf(fifo_ovf), .fifo_udf(fifo_udf)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    // Synchronous picture ROM: data appears one cycle after the address.
    always @(posedge pixel_clk) rom_rd_data <= rom_mem[rom_addr];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] adj_ch(input int c, input int g);
        int t, q, v, dv;
        dv = 1 << GF;
        t  = (c - 128) * g;
        q  = t / dv;
        if (t < 0 && (t % dv) != 0) q = q - 1;
        v = 128 + q;
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        return 8'(v);
    endfunction

    function automatic logic [23:0] adj_px(input logic [23:0] p, input int g);
        return {adj_ch(int'(p[23:16]), g), adj_ch(int'(p[15:8]), g), adj_ch(int'(p[7:0]), g)};
    endfunction

    function automatic logic [23:0] pic(input int x, input int y);
        return rom_mem[(y - YS) * W + (x - XS)];
    endfunction

    function automatic logic [23:0] exp_pixel(input int x, input int y);
        bit yin, inw, inc;
        yin = (y >= YS) && (y < YS + H);
        inw = yin && (x >= XS) && (x < XS + W);
        inc = yin && (x >= XS + W) && (x < XS + 2 * W);
        case (m_mode)
            2'd1:    return inw ? pic(x, y) : BACK;
            2'd2:    return inw ? adj_px(pic(x, y), int'(m_gain)) : BACK;
            2'd3:    return inw ? pic(x, y) : (inc ? adj_px(pic(x - W, y), int'(m_gain)) : BACK);
            default: return BACK;
        endcase
    endfunction

    task automatic fill_rom(input int kind);
        for (int i = 0; i < (1 << AW); i++) begin
            if (kind == 0)      rom_mem[i] = 24'($urandom);
            else if (kind == 1) rom_mem[i] = 24'(i);
            else                rom_mem[i] = 24'h906040;
        end
    endtask

    // One pixel: mode/gain are random except at frame start, where the frame's values are applied.
    task automatic step(input int x, input int y);
        @(negedge pixel_clk);
        pixel_xpos = 11'(x);
        pixel_ypos = 11'(y);
        if (x == 0 && y == 0) begin
            mode = f_mode; gain = f_gain; m_mode = f_mode; m_gain = f_gain;
        end else begin
            mode = 2'($urandom_range(3, 0));
            gain = 4'($urandom_range(15, 0));
        end
        if (x == rst_x && y == rst_y) begin
            #2 sys_rst_n = 1'b0;
            #1;
            check_eq("rst_pixel", 32'(pixel_data), 32'(BACK));
            check_eq("rst_rom_addr", 32'(rom_addr), 32'd0);
            check_eq("rst_flags", {30'd0, fifo_ovf, fifo_udf}, 32'd0);
            m_mode = 2'd0; m_gain = 4'd4;
            #1 sys_rst_n = 1'b1;
        end
        @(posedge pixel_clk);
        #1;
        check_eq($sformatf("pixel(%0d,%0d) mode%0d", x, y, m_mode), 32'(pixel_data), 32'(exp_pixel(x, y)));
        if (m_mode == 2'd0) check_eq("rom_addr_mode0", 32'(rom_addr), 32'd0);
    endtask

    task automatic run_frame(input logic [1:0] fm, input logic [3:0] fg);
        f_mode = fm;
        f_gain = fg;
        for (int y = 0; y < V_TOT; y++)
            for (int x = 0; x < H_TOT; x++)
                step(x, y);
        check_eq("rom_addr_eof", 32'(rom_addr), 32'd0);
    endtask

    task automatic drive_raw(input int x, input int y);
        @(negedge pixel_clk);
        pixel_xpos = 11'(x);
        pixel_ypos = 11'(y);
        mode = f_mode;
        gain = f_gain;
        @(posedge pixel_clk);
        #1;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        m_mode = 2'd0; m_gain = 4'd4; f_mode = 2'd0; f_gain = 4'd4;
        rst_x = -1; rst_y = -1;
        sys_rst_n = 1'b0;
        pixel_xpos = 11'd0; pixel_ypos = 11'd0; mode = 2'd0; gain = 4'd4;
        fill_rom(1);
        repeat (3) @(posedge pixel_clk);
        #1;
        check_eq("reset_pixel", 32'(pixel_data), 32'(BACK));
        check_eq("reset_rom_addr", 32'(rom_addr), 32'd0);
        check_eq("reset_flags", {30'd0, fifo_ovf, fifo_udf}, 32'd0);
        @(negedge pixel_clk);
        sys_rst_n = 1'b1;

        // No frame start seen yet: window pixels must stay background.
        for (int x = XS - 1; x < XS + 4; x++) step(x, YS);

        fill_rom(1); run_frame(2'd1, 4'd4);
        fill_rom(2); run_frame(2'd3, 4'd8);
        check_eq("flags_const_m3", {30'd0, fifo_ovf, fifo_udf}, 32'd0);
        fill_rom(0); run_frame(2'd2, 4'd4); run_frame(2'd1, 4'd4); run_frame(2'd2, 4'd0);
        repeat (6) begin
            fill_rom(0);
            run_frame(2'($urandom_range(3, 0)), 4'($urandom_range(15, 0)));
        end
        rst_x = XS + 3; rst_y = YS + 1;
        run_frame(2'd3, 4'($urandom_range(15, 0)));
        rst_x = -1; rst_y = -1;
        run_frame(2'd3, 4'($urandom_range(15, 0)));
        check_eq("flags_clean", {30'd0, fifo_ovf, fifo_udf}, 32'd0);

        // Forced read with an empty line buffer, then forced overfill.
        f_mode = 2'd3; f_gain = 4'd4;
        step(0, 0);
        drive_raw(0, YS);
        drive_raw(XS + W - 1, YS);
        check_eq("udf_set", {31'd0, fifo_udf}, 32'd1);
        check_eq("ovf_clear", {31'd0, fifo_ovf}, 32'd0);
        for (int x = 1; x < 4; x++) drive_raw(x, YS + 1);
        check_eq("udf_sticky", {31'd0, fifo_udf}, 32'd1);
        drive_raw(0, YS);
        repeat (W + 6) drive_raw(XS, YS);
        check_eq("ovf_set", {31'd0, fifo_ovf}, 32'd1);
        check_eq("udf_still", {31'd0, fifo_udf}, 32'd1);
        @(negedge pixel_clk);
        sys_rst_n = 1'b0;
        #1;
        check_eq("flags_after_rst", {30'd0, fifo_ovf, fifo_udf}, 32'd0);
        check_eq("pixel_after_rst", 32'(pixel_data), 32'(BACK));
        #2 sys_rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
